// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard receiver.
//   dec_state_t         - scan-code prefix decoder states
//   PS2_EXT / PS2_BRK   - Set-2 extended and break prefix bytes
//   KC_*                - HID usage codes produced for the mapped keys
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BREAK,
        EXT_BREAK
    } dec_state_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam logic [7:0] KC_ENTER = 8'h28;
    localparam logic [7:0] KC_SPACE = 8'h2C;
    localparam logic [7:0] KC_3     = 8'h20;
    localparam logic [7:0] KC_Z     = 8'h1D;
    localparam logic [7:0] KC_X     = 8'h1B;
    localparam logic [7:0] KC_W     = 8'h1A;
    localparam logic [7:0] KC_A     = 8'h04;
    localparam logic [7:0] KC_S     = 8'h16;
    localparam logic [7:0] KC_D     = 8'h07;
    localparam logic [7:0] KC_ESC   = 8'h29;
    localparam logic [7:0] KC_UP    = 8'h52;
    localparam logic [7:0] KC_DOWN  = 8'h51;
    localparam logic [7:0] KC_LEFT  = 8'h50;
    localparam logic [7:0] KC_RIGHT = 8'h4F;

endpackage

// File: rtl/ps2_scan_to_hid.sv
// ps2_scan_to_hid: combinational Set-2 scan code to HID keycode lookup.
//   ext   in  1  scan code was preceded by the E0 prefix
//   scan  in  8  Set-2 scan code byte
//   hid   out 8  HID code, 8'h00 for any key the game does not use
module ps2_scan_to_hid
    import ps2_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] scan,
    output logic [7:0] hid
);

    always_comb begin
        // NOTE: default first so every path assigns hid and no latch is inferred.
        hid = 8'h00;
        unique case ({ext, scan})
            9'h05A:  hid = KC_ENTER;
            9'h029:  hid = KC_SPACE;
            9'h026:  hid = KC_3;
            9'h01A:  hid = KC_Z;
            9'h022:  hid = KC_X;
            9'h01D:  hid = KC_W;
            9'h01C:  hid = KC_A;
            9'h01B:  hid = KC_S;
            9'h023:  hid = KC_D;
            9'h076:  hid = KC_ESC;
            9'h175:  hid = KC_UP;
            9'h172:  hid = KC_DOWN;
            9'h16B:  hid = KC_LEFT;
            9'h174:  hid = KC_RIGHT;
            default: hid = 8'h00;
        endcase
    end

endmodule

// File: rtl/ps2_keycode.sv
// ps2_keycode: receive-only PS/2 keyboard front end producing a held-key HID code.
//   TIMEOUT_CYCLES  idle Clk cycles after a PS/2 falling edge before a partial frame is dropped
//   Clk        in  1  system clock, rising edge
//   Reset_n    in  1  asynchronous active-low reset
//   PS2_CLK    in  1  raw keyboard clock (asynchronous, idle high)
//   PS2_DATA   in  1  raw keyboard data  (asynchronous, idle high)
//   keycode    out 8  HID code of the held mapped key, 8'h00 when none
//   key_valid  out 1  one-cycle pulse when keycode changes
//   frame_err  out 1  one-cycle pulse on bad start/parity/stop bit or timeout
module ps2_keycode
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] keycode,
    output logic       key_valid,
    output logic       frame_err
);

    localparam int               TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    // Synchronizers, edge detect and sampled data bit.
    logic clk_s1, clk_s2, clk_prev;
    logic data_s1, data_s2;
    logic strobe, data_bit;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            strobe   <= 1'b0;
            data_bit <= 1'b1;
        end else begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            data_s1  <= PS2_DATA;
            data_s2  <= data_s1;
            strobe   <= clk_prev & ~clk_s2;
            data_bit <= data_s2;
        end
    end

    // Framing.
    logic [3:0]      bit_cnt;
    logic [7:0]      data_bits;
    logic [TO_W-1:0] to_cnt;
    logic            discard;   // parity already failed; swallow the stop bit silently

    logic err_start, err_par, err_stop, timeout, byte_ok, err_any;

    always_comb begin
        err_start = strobe && (bit_cnt == 4'd0) && data_bit;
        err_par   = strobe && (bit_cnt == 4'd9) && !(^{data_bits, data_bit});
        err_stop  = strobe && (bit_cnt == 4'd10) && !data_bit && !discard;
        byte_ok   = strobe && (bit_cnt == 4'd10) &&  data_bit && !discard;
        // A strobe in the same cycle clears the counter, so it wins over the timeout.
        timeout   = !strobe && (bit_cnt != 4'd0) && (to_cnt == TO_LAST);
        err_any   = err_start || err_par || err_stop || timeout;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bit_cnt   <= 4'd0;
            data_bits <= 8'h00;
            to_cnt    <= '0;
            discard   <= 1'b0;
        end else if (strobe) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd10) begin
                bit_cnt <= 4'd0;
                discard <= 1'b0;
            end else if (!err_start) begin
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (bit_cnt >= 4'd1 && bit_cnt <= 4'd8)
                data_bits <= {data_bit, data_bits[7:1]};   // LSB arrives first
            if (err_par)
                discard <= 1'b1;
        end else if (timeout) begin
            bit_cnt <= 4'd0;
            to_cnt  <= '0;
            discard <= 1'b0;
        end else if (bit_cnt != 4'd0) begin
            to_cnt <= to_cnt + TO_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end

    // Prefix decoder.
    dec_state_t state, state_next;
    logic [7:0] keycode_next;
    logic       key_valid_next;
    logic       ext;
    logic [7:0] hid;

    assign ext = (state == EXT) || (state == EXT_BREAK);

    ps2_scan_to_hid u_map (
        .ext  (ext),
        .scan (data_bits),
        .hid  (hid)
    );

    always_comb begin
        state_next     = state;
        keycode_next   = keycode;
        key_valid_next = 1'b0;
        if (err_any) begin
            state_next = IDLE;
        end else if (byte_ok) begin
            unique case (state)
                IDLE, EXT: begin
                    if (state == IDLE && data_bits == PS2_EXT) begin
                        state_next = EXT;
                    end else if (data_bits == PS2_BRK) begin
                        state_next = (state == IDLE) ? BREAK : EXT_BREAK;
                    end else begin
                        state_next = IDLE;
                        if (hid != 8'h00 && hid != keycode) begin
                            keycode_next   = hid;
                            key_valid_next = 1'b1;
                        end
                    end
                end
                BREAK, EXT_BREAK: begin
                    state_next = IDLE;
                    // Releasing a key other than the held one leaves keycode alone.
                    if (hid != 8'h00 && hid == keycode) begin
                        keycode_next   = 8'h00;
                        key_valid_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            keycode   <= 8'h00;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_next;
            keycode   <= keycode_next;
            key_valid <= key_valid_next;
            frame_err <= err_any;
        end
    end

endmodule

// File: tb/tb_ps2_keycode.sv
// tb_ps2_keycode: self-checking bench for ps2_keycode with a byte-level reference model.
module tb_ps2_keycode;

    localparam int HALF = 8;   // Clk cycles per PS/2 clock half period

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DATA = 1'b1;
    logic [7:0] keycode;
    logic       key_valid;
    logic       frame_err;

    always #5 Clk = ~Clk;

    ps2_keycode #(.TIMEOUT_CYCLES(50000)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .PS2_CLK   (PS2_CLK),
        .PS2_DATA  (PS2_DATA),
        .keycode   (keycode),
        .key_valid (key_valid),
        .frame_err (frame_err)
    );

    int errors = 0;
    int checks = 0;

    // Pulse monitor.
    int   kv_cnt = 0, fe_cnt = 0, overlap_cnt = 0, long_cnt = 0;
    logic kv_q = 1'b0, fe_q = 1'b0;
    always @(negedge Clk) begin
        if (key_valid) kv_cnt++;
        if (frame_err) fe_cnt++;
        if (key_valid && frame_err) overlap_cnt++;
        if ((key_valid && kv_q) || (frame_err && fe_q)) long_cnt++;
        kv_q = key_valid;
        fe_q = frame_err;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: key table plus two prefix flags.
    logic [7:0] hid_map [logic [8:0]];
    logic [7:0] m_kc = 8'h00;
    bit         m_ext = 1'b0, m_brk = 1'b0;

    function automatic logic [7:0] lookup(input bit e, input logic [7:0] b);
        logic [8:0] k;
        k = {e, b};
        return hid_map.exists(k) ? hid_map[k] : 8'h00;
    endfunction

    task automatic model_apply(input logic [7:0] b, output int chg);
        logic [7:0] old, h;
        old = m_kc;
        if (m_brk) begin
            h = lookup(m_ext, b);
            if (h != 8'h00 && h == m_kc) m_kc = 8'h00;
            m_brk = 1'b0;
            m_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!m_ext && b == 8'hE0) begin
            m_ext = 1'b1;
        end else begin
            h = lookup(m_ext, b);
            if (h != 8'h00) m_kc = h;
            m_ext = 1'b0;
        end
        chg = (m_kc != old) ? 1 : 0;
    endtask

    task automatic model_error();
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    // Shift out the first nbits of a frame; optionally check stop-bit latency.
    task automatic send_bits(input logic [10:0] bits, input int nbits, input bit check_lat);
        for (int i = 0; i < nbits; i++) begin
            PS2_DATA = bits[i];
            idle(HALF);
            PS2_CLK = 1'b0;
            if (check_lat && i == 10) begin
                for (int k = 1; k <= 4; k++) begin
                    @(negedge Clk);
                    chk($sformatf("lat_edge%0d", k), key_valid, (k == 4) ? 1 : 0);
                end
                idle(HALF - 4);
            end else begin
                idle(HALF);
            end
            PS2_CLK = 1'b1;
        end
        PS2_DATA = 1'b1;
        idle(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int kv0, chg;
        kv0 = kv_cnt;
        send_bits(frame_bits(b, 1'b0), 11, 1'b0);
        idle(4);
        model_apply(b, chg);
        chk($sformatf("kc_after_%02h", b), keycode, m_kc);
        chk($sformatf("kv_after_%02h", b), kv_cnt - kv0, chg);
    endtask

    logic [7:0] pool [20] = '{8'h5A, 8'h29, 8'h26, 8'h1A, 8'h22, 8'h1D, 8'h1C, 8'h1B,
                              8'h23, 8'h76, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hE0, 8'hF0,
                              8'hF0, 8'hE0, 8'h12, 8'h33};

    initial begin
        int kv0, fe0, chg;

        hid_map[9'h05A] = 8'h28; hid_map[9'h029] = 8'h2C; hid_map[9'h026] = 8'h20;
        hid_map[9'h01A] = 8'h1D; hid_map[9'h022] = 8'h1B; hid_map[9'h01D] = 8'h1A;
        hid_map[9'h01C] = 8'h04; hid_map[9'h01B] = 8'h16; hid_map[9'h023] = 8'h07;
        hid_map[9'h076] = 8'h29; hid_map[9'h175] = 8'h52; hid_map[9'h172] = 8'h51;
        hid_map[9'h16B] = 8'h50; hid_map[9'h174] = 8'h4F;

        // Reset state.
        idle(3);
        chk("rst_keycode", keycode, 8'h00);
        chk("rst_key_valid", key_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        Reset_n = 1'b1;
        idle(5);

        // Enter press with exact latency, then release.
        kv0 = kv_cnt;
        send_bits(frame_bits(8'h5A, 1'b0), 11, 1'b1);
        idle(4);
        model_apply(8'h5A, chg);
        chk("enter_kc", keycode, 8'h28);
        chk("enter_pulses", kv_cnt - kv0, 1);
        send_byte(8'hF0);
        send_byte(8'h5A);
        chk("enter_release", keycode, 8'h00);

        // Extended Up press/release; plain 75 is unmapped.
        send_byte(8'hE0);
        send_byte(8'h75);
        chk("up_kc", keycode, 8'h52);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        chk("up_release", keycode, 8'h00);
        send_byte(8'h75);

        // Typematic repeat.
        kv0 = kv_cnt;
        send_byte(8'h1A);
        send_byte(8'h1A);
        send_byte(8'h1A);
        chk("repeat_kc", keycode, 8'h1D);
        chk("repeat_pulses", kv_cnt - kv0, 1);

        // Last pressed wins; releasing the older key is ignored.
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h1A);
        chk("stale_release", keycode, 8'h04);
        send_byte(8'hF0);
        send_byte(8'h1C);
        chk("a_release", keycode, 8'h00);

        // Parity error.
        send_byte(8'h1B);
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(frame_bits(8'h5A, 1'b1), 11, 1'b0);
        idle(4);
        model_error();
        chk("par_fe_pulses", fe_cnt - fe0, 1);
        chk("par_kv_pulses", kv_cnt - kv0, 0);
        chk("par_kc", keycode, 8'h16);
        send_byte(8'h29);
        chk("space_kc", keycode, 8'h2C);

        // Randomized byte stream against the model.
        for (int n = 0; n < 60; n++)
            send_byte(pool[$urandom_range(0, 19)]);

        // Timeout after a partial frame.
        kv0 = kv_cnt;
        fe0 = fe_cnt;
        send_bits(frame_bits(8'h33, 1'b0), 5, 1'b0);
        idle(50010);
        model_error();
        chk("to_fe_pulses", fe_cnt - fe0, 1);
        chk("to_kv_pulses", kv_cnt - kv0, 0);
        send_byte(8'h5A);
        chk("to_recover_kc", keycode, 8'h28);

        // Reset asserted mid-frame.
        send_bits(frame_bits(8'h1C, 1'b0), 5, 1'b0);
        Reset_n = 1'b0;
        #1;
        chk("midrst_keycode", keycode, 8'h00);
        chk("midrst_key_valid", key_valid, 0);
        chk("midrst_frame_err", frame_err, 0);
        idle(3);
        Reset_n = 1'b1;
        m_kc = 8'h00;
        model_error();
        idle(5);
        send_byte(8'h1C);
        chk("post_rst_kc", keycode, 8'h04);

        // Global pulse properties.
        chk("fe_total", fe_cnt, 2);
        chk("pulse_overlap", overlap_cnt, 0);
        chk("pulse_long", long_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
